// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
//
// Run controller for the single-cycle core. Gates the core clock enable and
// sequences execution under host control: free run, single step, a cycle
// budget and (optionally) PC breakpoints. Reports why execution stopped.
//
// Build option:
//   CORE_RUN_BP_EN  defined   -> NUM_BP PC comparators plus the resume flag
//                                that suppresses a breakpoint on the first RUN
//                                cycle after entry; halt cause 3 reachable.
//                   undefined -> no comparators, i_pc/i_bp_addr/i_bp_en are
//                                ignored, o_bp_hit is tied to 0.
//
// Parameters:
//   PC_W    width of the core PC
//   CNT_W   width of the executed-cycle counter
//   NUM_BP  number of breakpoint comparators (>= 1)
//
// Ports:
//   i_clk          core clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_run          pulse: start/resume free run
//   i_step         pulse: execute exactly one core cycle
//   i_halt         pulse: host stop request (RUN only)
//   i_clr          pulse: clear counter / return to IDLE (IDLE/HALT only)
//   i_cycle_limit  cycle budget, 0 = unlimited
//   i_pc           current core PC
//   i_bp_addr      breakpoint addresses, bp k at [k*PC_W +: PC_W]
//   i_bp_en        per-breakpoint enable
//   o_core_en      combinational clock enable to the core
//   o_state        IDLE=0, RUN=1, STEP=2, HALT=3
//   o_cycle_cnt    cycles executed (core_en high at a rising edge), saturating
//   o_halted       high while in HALT
//   o_halt_cause   0 step done, 1 host halt, 2 cycle limit, 3 breakpoint
//   o_bp_hit       breakpoints responsible for the last halt
// ---------------------------------------------------------------------------
module core_run_ctrl #(
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16,
    parameter int NUM_BP = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_halt,
    input  logic                   i_clr,
    input  logic [CNT_W-1:0]       i_cycle_limit,
    input  logic [PC_W-1:0]        i_pc,
    input  logic [NUM_BP*PC_W-1:0] i_bp_addr,
    input  logic [NUM_BP-1:0]      i_bp_en,
    output logic                   o_core_en,
    output logic [1:0]             o_state,
    output logic [CNT_W-1:0]       o_cycle_cnt,
    output logic                   o_halted,
    output logic [1:0]             o_halt_cause,
    output logic [NUM_BP-1:0]      o_bp_hit
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [1:0] CAUSE_STEP  = 2'd0;
    localparam logic [1:0] CAUSE_HOST  = 2'd1;
    localparam logic [1:0] CAUSE_LIMIT = 2'd2;
    localparam logic [1:0] CAUSE_BP    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;

    logic              in_run;
    logic              stop_host;
    logic              stop_limit;
    logic              stop_bp;
    logic              stop_any;
    logic              core_en;
    logic [NUM_BP-1:0] bp_match;

    assign in_run = (state_q == ST_RUN);

    // Stop terms are evaluated in the same cycle they are seen so the
    // instruction at a breakpoint PC (or past the budget) never executes.
    assign stop_host  = in_run && i_halt;
    assign stop_limit = in_run && (i_cycle_limit != '0) && (cnt_q >= i_cycle_limit);

`ifdef CORE_RUN_BP_EN
    // Set on every entry into RUN so that resuming from a breakpoint halt
    // executes the instruction at that PC instead of stopping again.
    logic resume_q, resume_d;

    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NUM_BP; k++) begin
            bp_match[k] = i_bp_en[k] && (i_pc == i_bp_addr[k*PC_W +: PC_W]);
        end
    end

    assign stop_bp  = in_run && !resume_q && (|bp_match);
    assign resume_d = (state_d == ST_RUN) && (state_q != ST_RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resume_q <= 1'b0;
        end else begin
            resume_q <= resume_d;
        end
    end
`else
    logic unused_bp_inputs;

    assign unused_bp_inputs = ^{i_pc, i_bp_addr, i_bp_en};
    assign bp_match         = '0;
    assign stop_bp          = 1'b0;
`endif

    assign stop_any = stop_host || stop_limit || stop_bp;
    assign core_en  = (state_q == ST_STEP) || (in_run && !stop_any);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        bp_hit_d = bp_hit_q;

        // Counter tracks executed cycles and sticks at all-ones.
        if (core_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end else if (i_clr) begin
                    cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (stop_any) begin
                    state_d = ST_HALT;
                    if (stop_host) begin
                        cause_d  = CAUSE_HOST;
                        bp_hit_d = '0;
                    end else if (stop_limit) begin
                        cause_d  = CAUSE_LIMIT;
                        bp_hit_d = '0;
                    end else begin
                        cause_d  = CAUSE_BP;
                        bp_hit_d = bp_match;
                    end
                end
            end
            ST_STEP: begin
                state_d  = ST_HALT;
                cause_d  = CAUSE_STEP;
                bp_hit_d = '0;
            end
            default: begin
                // HALT: run beats step beats clear.
                if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end else if (i_clr) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    cause_d  = CAUSE_STEP;
                    bp_hit_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cause_q  <= CAUSE_STEP;
            bp_hit_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign o_core_en    = core_en;
    assign o_state      = state_q;
    assign o_cycle_cnt  = cnt_q;
    assign o_halted     = (state_q == ST_HALT);
    assign o_halt_cause = cause_q;
    assign o_bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

    localparam int PC_W    = 8;
    localparam int CNT_W   = 5;
    localparam int NUM_BP  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reference-model activity modes (these numbers are also the visible
    // o_state values the host sees).
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic                   clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_run, i_step, i_halt, i_clr;
    logic [CNT_W-1:0]       i_cycle_limit;
    logic [PC_W-1:0]        i_pc;
    logic [NUM_BP*PC_W-1:0] i_bp_addr;
    logic [NUM_BP-1:0]      i_bp_en;
    logic                   o_core_en;
    logic [1:0]             o_state;
    logic [CNT_W-1:0]       o_cycle_cnt;
    logic                   o_halted;
    logic [1:0]             o_halt_cause;
    logic [NUM_BP-1:0]      o_bp_hit;

    always #5 clk = ~clk;

    core_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_run        (i_run),
        .i_step       (i_step),
        .i_halt       (i_halt),
        .i_clr        (i_clr),
        .i_cycle_limit(i_cycle_limit),
        .i_pc         (i_pc),
        .i_bp_addr    (i_bp_addr),
        .i_bp_en      (i_bp_en),
        .o_core_en    (o_core_en),
        .o_state      (o_state),
        .o_cycle_cnt  (o_cycle_cnt),
        .o_halted     (o_halted),
        .o_halt_cause (o_halt_cause),
        .o_bp_hit     (o_bp_hit)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    int              m_mode;
    int              m_exec;
    int              m_cause;
    logic [NUM_BP-1:0] m_hit;
    bit              m_fresh;

    // Toy core: PC advances by 4 on each enabled cycle, wrapping at 64.
    int              tb_pc;
    bit              last_en;
    int              en_count;
    logic [PC_W-1:0] bp_arr [NUM_BP];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NUM_BP-1:0] m_bp_hits();
        logic [NUM_BP-1:0] h;
        h = '0;
`ifdef CORE_RUN_BP_EN
        for (int k = 0; k < NUM_BP; k++) begin
            if (i_bp_en[k] && (tb_pc[PC_W-1:0] == bp_arr[k])) h[k] = 1'b1;
        end
`endif
        return h;
    endfunction

    // 0 = keep going, otherwise the halt cause the spec's priority picks.
    function automatic int m_stop(input bit h);
        if (m_mode != M_RUN) return 0;
        if (h) return 1;
        if ((i_cycle_limit != 0) && (m_exec >= int'(i_cycle_limit))) return 2;
        if (!m_fresh && (m_bp_hits() != 0)) return 3;
        return 0;
    endfunction

    task automatic m_reset();
        m_mode  = M_IDLE;
        m_exec  = 0;
        m_cause = 0;
        m_hit   = '0;
        m_fresh = 1'b0;
    endtask

    task automatic check_regs();
        chk("state",  o_state,      m_mode);
        chk("cnt",    o_cycle_cnt,  m_exec);
        chk("cause",  o_halt_cause, m_cause);
        chk("bp_hit", o_bp_hit,     m_hit);
        chk("halted", o_halted,     (m_mode == M_HALT));
    endtask

    // One clock cycle with the given pulses.
    task automatic tick(input bit r, input bit s, input bit h, input bit c);
        int                stop;
        bit                exp_en;
        logic [NUM_BP-1:0] hits;
        @(negedge clk);
        i_run  = r;
        i_step = s;
        i_halt = h;
        i_clr  = c;
        i_pc   = tb_pc[PC_W-1:0];
        for (int k = 0; k < NUM_BP; k++) i_bp_addr[k*PC_W +: PC_W] = bp_arr[k];
        #1;
        stop   = m_stop(h);
        hits   = m_bp_hits();
        exp_en = (m_mode == M_STEP) || ((m_mode == M_RUN) && (stop == 0));
        chk("core_en", o_core_en, exp_en);
        last_en = o_core_en;
        if (o_core_en) en_count++;
        @(posedge clk);
        if (exp_en) m_exec = (m_exec < CNT_MAX) ? m_exec + 1 : CNT_MAX;
        if (last_en) tb_pc = (tb_pc + 4) % 64;
        case (m_mode)
            M_IDLE: begin
                if (r) begin
                    m_mode = M_RUN; m_fresh = 1'b1;
                end else if (s) begin
                    m_mode = M_STEP;
                end else if (c) begin
                    m_exec = 0;
                end
            end
            M_RUN: begin
                m_fresh = 1'b0;
                if (stop != 0) begin
                    m_mode  = M_HALT;
                    m_cause = stop;
                    m_hit   = (stop == 3) ? hits : '0;
                end
            end
            M_STEP: begin
                m_mode = M_HALT; m_cause = 0; m_hit = '0;
            end
            default: begin
                if (r) begin
                    m_mode = M_RUN; m_fresh = 1'b1;
                end else if (s) begin
                    m_mode = M_STEP;
                end else if (c) begin
                    m_mode = M_IDLE; m_exec = 0; m_cause = 0; m_hit = '0;
                end
            end
        endcase
        #1;
        check_regs();
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic do_reset();
        @(negedge clk);
        i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0; i_clr = 1'b0;
        i_rst_n = 1'b0;
        #1;
        m_reset();
        tb_pc = 0;
        chk("rst_core_en", o_core_en, 1'b0);
        check_regs();
        @(posedge clk);
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0; i_clr = 1'b0;
        i_cycle_limit = '0;
        i_pc = '0;
        i_bp_addr = '0;
        i_bp_en = '0;
        bp_arr[0] = 8'h00;
        bp_arr[1] = 8'h00;
        tb_pc = 0;
        m_reset();
        do_reset();

        // Budget of 11 cycles.
        i_cycle_limit = 11;
        tick(1, 0, 0, 0);
        en_count = 0;
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0);
        chk("lim_en_cycles", en_count, 11);
        chk("lim_cnt", o_cycle_cnt, 11);
        chk("lim_cause", o_halt_cause, 2);
        chk("lim_state", o_state, M_HALT);

        // Three single steps, unlimited budget.
        i_cycle_limit = 0;
        tick(0, 0, 0, 1);
        chk("clr_state", o_state, M_IDLE);
        en_count = 0;
        for (int n = 1; n <= 3; n++) begin
            tick(0, 1, 0, 0);
            for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
            chk("step_cnt", o_cycle_cnt, n);
            chk("step_cause", o_halt_cause, 0);
        end
        chk("step_en_cycles", en_count, 3);

        // Breakpoint at PC 8.
        tick(0, 0, 0, 1);
        tb_pc = 0;
        bp_arr[0] = 8'h08;
        bp_arr[1] = 8'h30;
        i_bp_en = 2'b01;
        tick(1, 0, 0, 0);
`ifdef CORE_RUN_BP_EN
        for (int i = 0; i < 10 && !o_halted; i++) tick(0, 0, 0, 0);
        chk("bp_cnt", o_cycle_cnt, 2);
        chk("bp_cause", o_halt_cause, 3);
        chk("bp_hit", o_bp_hit, 2'b01);
        chk("bp_pc", tb_pc, 8);
        chk("bp_en_low", last_en, 1'b0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("bp_resume_en", last_en, 1'b1);
        chk("bp_resume_pc", tb_pc, 12);
        chk("bp_resume_state", o_state, M_RUN);
`else
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        chk("nobp_state", o_state, M_RUN);
        chk("nobp_cnt", o_cycle_cnt, 5);
        chk("nobp_hit", o_bp_hit, 0);
`endif
        tick(0, 0, 1, 0);
        chk("bp_stop_state", o_state, M_HALT);

        // Host halt in the 6th RUN cycle.
        i_bp_en = 2'b00;
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("halt_cnt", o_cycle_cnt, 5);
        chk("halt_cause", o_halt_cause, 1);
        chk("halt_hit", o_bp_hit, 0);

        // Counter saturation.
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 8; i++) tick(0, 0, 0, 0);
        chk("sat_cnt", o_cycle_cnt, CNT_MAX);
        chk("sat_state", o_state, M_RUN);

        // Reset while running.
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        chk("pre_rst_en", last_en, 1'b1);
        do_reset();
        chk("post_rst_state", o_state, M_IDLE);
        chk("post_rst_cnt", o_cycle_cnt, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) i_cycle_limit = CNT_W'($urandom_range(0, 24));
            if (i % 25 == 0) begin
                for (int k = 0; k < NUM_BP; k++) bp_arr[k] = PC_W'($urandom_range(0, 15) * 4);
                i_bp_en = NUM_BP'($urandom);
            end
            if (i % 200 == 199) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised run controller for the single-cycle core: it gates the core's clock enable and runs the program under host control. It supports free-run, single-step, a cycle budget and PC breakpoints, and reports why execution stopped. It sits between the simulation/host harness and `core`, replacing a fixed stop-after-N-cycles run with a synthesizable, reusable controller.

## Interface
Parameters:
- PC_W, 32, width of the core PC
- CNT_W, 16, width of the executed-cycle counter
- NUM_BP, 2, number of PC breakpoint comparators (≥1)

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_run  in  1  one-cycle pulse: start/resume free run
- i_step  in  1  one-cycle pulse: execute exactly one core cycle
- i_halt  in  1  one-cycle pulse: host stop request
- i_clr  in  1  one-cycle pulse: clear counter, return to IDLE (honoured in IDLE/HALT only)
- i_cycle_limit  in  CNT_W  cycle budget; 0 = unlimited
- i_pc  in  PC_W  current PC from core
- i_bp_addr  in  NUM_BP*PC_W  breakpoint addresses, bp k at [k*PC_W +: PC_W]
- i_bp_en  in  NUM_BP  per-breakpoint enable
- o_core_en  out  1  clock enable to core (combinational)
- o_state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
- o_cycle_cnt  out  CNT_W  cycles executed (core_en high at a rising edge)
- o_halted  out  1  high in HALT
- o_halt_cause  out  2  0 step done, 1 host halt, 2 cycle limit, 3 breakpoint
- o_bp_hit  out  NUM_BP  one-hot(s) of breakpoints that caused last halt

## Operation
- Reset: state IDLE, o_cycle_cnt 0, o_halted 0, o_halt_cause 0, o_bp_hit 0, resume flag 0; o_core_en 0.
- IDLE: i_run → RUN; else i_step → STEP; i_halt ignored; i_clr clears counter.
- RUN: stop terms evaluated combinationally each cycle, priority i_halt > limit > breakpoint:
  - limit: i_cycle_limit≠0 and o_cycle_cnt ≥ i_cycle_limit
  - bp: any k with i_bp_en[k] and i_pc == bp k, suppressed on the first RUN cycle after entry (resume flag)
  - any stop term: o_core_en=0 this cycle, next state HALT, cause latched, o_bp_hit latched (matching bits, only for cause 3, else 0)
  - no stop term: o_core_en=1, stay RUN
- STEP: o_core_en=1 for one cycle, next HALT, cause 0. Breakpoints and limit not checked in STEP.
- HALT: i_run → RUN (counter continues); else i_step → STEP; i_clr → IDLE, counter 0, cause 0, o_bp_hit 0.
- Counter: +1 on each rising edge with o_core_en=1; saturates at all-ones.
- Pulses arriving in states where they have no transition are dropped, not queued.

## Timing
- o_state, o_cycle_cnt, o_halted, o_halt_cause, o_bp_hit registered; update on the edge ending the decision cycle.
- o_core_en combinational from state, i_halt, counter, limit, i_pc, bp inputs; zero latency stop: instruction at a breakpoint PC is not executed.
- i_run/i_step edge at cycle n → o_core_en first high in cycle n+1.
- Async reset asserted mid-RUN: o_core_en drops to 0 immediately (state is async-reset), all outputs to reset values.
- Simultaneous i_run and i_step: i_run wins. i_clr with i_run in HALT: i_run wins.
- Limit already reached on entering RUN: zero cycles executed, HALT cause 2.

## Configuration
- CORE_RUN_BP_EN defined: NUM_BP comparators and resume-suppress flag built; cause 3 reachable.
- Undefined: no comparators; i_bp_addr/i_bp_en ignored, o_bp_hit tied 0, cause 3 never produced; all other behaviour identical.

## Test plan
- Reset, limit=11, i_run pulse → o_core_en high exactly 11 consecutive cycles, then HALT, cnt=11, cause=2.
- Limit=0, three i_step pulses 4 cycles apart → three single-cycle core_en pulses, cnt=3, cause=0 after each.
- CORE_RUN_BP_EN, bp0=0x8 enabled, PC 0,4,8 → core_en low with pc=8, cnt=2, cause=3, o_bp_hit=2'b01; i_run → executes pc=8 (suppressed), continues.
- Limit=0, RUN, i_halt in 6th RUN cycle → cnt=5, cause=1, o_bp_hit=0.
- RUN, assert i_rst_n=0 between edges → core_en 0 immediately, state IDLE, cnt 0.
- Macro undefined, same bp setup as scenario 3 → no halt at pc=8, o_bp_hit stays 0.
